// File: rtl/PARAMS_pkg.sv
// Shared pipeline widths and the writeback pending-buffer entry type.
package PARAMS_pkg;

  localparam int WD_SIZE        = 32;
  localparam int INSTR_REG_SIZE = 5;
  localparam int PEND_DEPTH_DEF = 2;

  typedef struct packed {
    logic                      valid;
    logic [INSTR_REG_SIZE-1:0] rd;
    logic [WD_SIZE-1:0]        data;
  } pend_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer for mul/div results waiting on the register-file write port.
// Entries can be squashed by rd; head is always kept on a live entry or the buffer is empty.
module wb_pend_fifo
  import PARAMS_pkg::*;
#(
  parameter  int DEPTH = PEND_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [INSTR_REG_SIZE-1:0]       push_rd,
  input  logic [WD_SIZE-1:0]              push_data,
  input  logic                            pop,
  input  logic                            squash_en,
  input  logic [INSTR_REG_SIZE-1:0]       squash_rd,
  output logic [CW-1:0]                   count,
  output pend_entry_t                     head_entry,
  output logic [DEPTH-1:0]                slot_valid,
  output logic [DEPTH*INSTR_REG_SIZE-1:0] slot_rd
);

  pend_entry_t     mem_q [DEPTH];
  pend_entry_t     mem_n [DEPTH];
  logic [PW-1:0]   head_q, head_n;
  logic [PW-1:0]   tail_q, tail_n;
  logic [CW-1:0]   count_q, count_n;

  // Squash existing entries before the push so a same-cycle push is never squashed.
  always_comb begin
    mem_n   = mem_q;
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_n[i].valid && mem_n[i].rd == squash_rd) mem_n[i].valid = 1'b0;
      end
    end
    if (pop) begin
      mem_n[head_n].valid = 1'b0;
      head_n  = head_n + 1'b1;
      count_n = count_n - 1'b1;
    end
    if (push) begin
      mem_n[tail_n] = '{valid: 1'b1, rd: push_rd, data: push_data};
      tail_n  = tail_n + 1'b1;
      count_n = count_n + 1'b1;
    end
    // Retire squashed entries at the head so they never cost a write cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (count_n != '0 && !mem_n[head_n].valid) begin
        head_n  = head_n + 1'b1;
        count_n = count_n - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_n[i];
    end
  end

  always_comb begin
    slot_valid = '0;
    slot_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i]                            = mem_q[i].valid;
      slot_rd[i*INSTR_REG_SIZE +: INSTR_REG_SIZE] = mem_q[i].rd;
    end
  end

  assign count      = count_q;
  assign head_entry = mem_q[head_q];

endmodule

// File: rtl/stage_writeback.sv
// Writeback stage: arbitrates the mem path and mul/div path onto one register-file write port,
// parking losing mul/div results in a small pending buffer.
module stage_writeback
  import PARAMS_pkg::*;
#(
  parameter int WD_SIZE        = PARAMS_pkg::WD_SIZE,
  parameter int INSTR_REG_SIZE = PARAMS_pkg::INSTR_REG_SIZE,
  parameter int PEND_DEPTH     = PEND_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ctrl_reg_write_mem_i,
  input  logic                                 ctrl_ld_mem_i,
  input  logic [INSTR_REG_SIZE-1:0]            rd_mem_i,
  input  logic [WD_SIZE-1:0]                   alu_result_mem_i,
  input  logic [WD_SIZE-1:0]                   mem_data_mem_i,
  input  logic                                 ctrl_reg_write_ml_i,
  input  logic [INSTR_REG_SIZE-1:0]            rd_ml_i,
  input  logic [WD_SIZE-1:0]                   result_ml_i,
  output logic                                 ctrl_reg_write_o,
  output logic [INSTR_REG_SIZE-1:0]            wr_rd_o,
  output logic [WD_SIZE-1:0]                   wr_data_o,
  output logic                                 stall_ml_o,
  output logic [PEND_DEPTH-1:0]                pend_valid_o,
  output logic [PEND_DEPTH*INSTR_REG_SIZE-1:0] pend_rd_o,
  output logic                                 overflow_o,
  output logic [31:0]                          wb_count_o
);

  localparam int CW = $clog2(PEND_DEPTH + 1);

  logic                      mem_req, ml_req;
  logic                      buf_nonempty, buf_full;
  logic                      push, pop, drop;
  logic                      wr_en_n;
  logic [INSTR_REG_SIZE-1:0] wr_rd_n;
  logic [WD_SIZE-1:0]        wr_data_n;
  logic [CW-1:0]             fifo_count;
  pend_entry_t               head_entry;

  assign mem_req      = ctrl_reg_write_mem_i && (rd_mem_i != '0);
  assign ml_req       = ctrl_reg_write_ml_i && (rd_ml_i != '0);
  assign buf_nonempty = head_entry.valid;
  assign buf_full     = (fifo_count == CW'(PEND_DEPTH));

  // Port priority: mem path, then buffered head, then direct mul/div bypass.
  always_comb begin
    wr_en_n   = 1'b0;
    wr_rd_n   = wr_rd_o;
    wr_data_n = wr_data_o;
    pop       = 1'b0;
    if (mem_req) begin
      wr_en_n   = 1'b1;
      wr_rd_n   = rd_mem_i;
      wr_data_n = ctrl_ld_mem_i ? mem_data_mem_i : alu_result_mem_i;
    end else if (buf_nonempty) begin
      wr_en_n   = 1'b1;
      wr_rd_n   = head_entry.rd;
      wr_data_n = head_entry.data;
      pop       = 1'b1;
    end else if (ml_req) begin
      wr_en_n   = 1'b1;
      wr_rd_n   = rd_ml_i;
      wr_data_n = result_ml_i;
    end
  end

  assign push = ml_req && (mem_req || buf_nonempty) && (!buf_full || pop);
  assign drop = ml_req && (mem_req || buf_nonempty) && buf_full && !pop;

  wb_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_rd    (rd_ml_i),
    .push_data  (result_ml_i),
    .pop        (pop),
    .squash_en  (mem_req),
    .squash_rd  (rd_mem_i),
    .count      (fifo_count),
    .head_entry (head_entry),
    .slot_valid (pend_valid_o),
    .slot_rd    (pend_rd_o)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg_write_o <= 1'b0;
      wr_rd_o          <= '0;
      wr_data_o        <= '0;
      overflow_o       <= 1'b0;
      wb_count_o       <= '0;
    end else begin
      ctrl_reg_write_o <= wr_en_n;
      wr_rd_o          <= wr_rd_n;
      wr_data_o        <= wr_data_n;
      overflow_o       <= overflow_o | drop;
      wb_count_o       <= wb_count_o + {31'b0, wr_en_n};
    end
  end

  assign stall_ml_o = buf_full;

endmodule
